axi_burst_arbiter: RTL

- N-input round-robin arbiter that merges several buffered AXI channel streams, e.g. per-master W or R FIFO outputs, into one output stream.
- Sits directly downstream of the per-port FIFO buffers in the node. Consumes their data/valid/ready outputs and drives a single downstream channel.
- Arbitrates per burst: once a source wins, it owns the output until its last beat transfers. This keeps bursts unbroken and keeps AXI valid/data stable while stalled.

---
 rtl/axi_node_pkg.sv | 55 +++++
 rtl/axi_rr_priority_sel.sv | 33 +++
 rtl/axi_burst_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// -----------------------------------------------------------------------------
// axi_node_pkg
// Shared definitions for the AXI node datapath blocks.
//   - lock_state_t / UNLOCKED / LOCKED : burst-ownership state of an arbiter
//   - rr_first_set()                   : round-robin "first set bit at or after
//                                        pointer, with wrap-around" search
// Arbiters using rr_first_set() are limited to RR_MAX_N requesters.
// -----------------------------------------------------------------------------
package axi_node_pkg;

    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IDX_W = 5;

    // Burst ownership state; kept as a plain vector with named constants so
    // the encoding is fixed and visible in waveforms.
    typedef logic [0:0] lock_state_t;
    localparam lock_state_t UNLOCKED = 1'b0;
    localparam lock_state_t LOCKED   = 1'b1;

    // Returns the first index k with req[k]=1, searching ptr, ptr+1, ... modulo
    // n. When nothing is requested the pointer itself is returned so the
    // idle selection is stable. Requires ptr < n <= RR_MAX_N.
    function automatic int unsigned rr_first_set(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         ptr,
        input int unsigned         n
    );
        int unsigned res;
        int unsigned idx;
        logic        found;
        res   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_N; i++) begin
            if (i < n) begin
                idx = ptr + i;
                // ptr < n, so a single subtraction is enough for the wrap
                if (idx >= n) begin
                    idx = idx - n;
                end else begin
                    idx = idx;
                end
                if (!found && req[idx[RR_IDX_W-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                idx = 32'd0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_rr_priority_sel.sv
// -----------------------------------------------------------------------------
// axi_rr_priority_sel
// Pure combinational round-robin selector: picks the first asserted request at
// or after the pointer, wrapping modulo N_IN.
// Ports:
//   req_i       [N_IN]      request vector
//   ptr_i       [LOG_N_IN]  search start index (must be < N_IN)
//   grant_o     [LOG_N_IN]  selected index (equals ptr_i when no request)
//   any_valid_o             at least one request is asserted
// -----------------------------------------------------------------------------
module axi_rr_priority_sel
    import axi_node_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int LOG_N_IN = 2
) (
    input  logic [N_IN-1:0]     req_i,
    input  logic [LOG_N_IN-1:0] ptr_i,
    output logic [LOG_N_IN-1:0] grant_o,
    output logic                any_valid_o
);

    logic [RR_MAX_N-1:0] req_ext_s;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext_s             = '0;
        req_ext_s[N_IN-1:0]   = req_i;
        grant_o               = LOG_N_IN'(rr_first_set(req_ext_s, 32'(ptr_i), N_IN));
        any_valid_o           = |req_i;
    end

endmodule

// File: rtl/axi_burst_arbiter.sv
// -----------------------------------------------------------------------------
// axi_burst_arbiter
// N-input round-robin arbiter merging buffered AXI channel streams into one.
// A winner owns the output until its last beat transfers; an offered beat
// (stalled or non-last) locks the selection so valid/data stay stable.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   data_i  [N_IN*DW]      packed payloads, input k at [k*DW +: DW]
//   valid_i, last_i [N_IN] per-input valid / last-beat flag
//   ready_o [N_IN]         per-input ready, one-hot or zero
//   data_o, last_o, id_o   selected payload, last flag, granted index
//   valid_o / ready_i      downstream handshake
// Optional feature (macro AXI_BURST_ARBITER_OUT_REG_EN): one-entry output
// register slice after the mux; valid_i -> valid_o latency becomes 1 cycle.
// -----------------------------------------------------------------------------
module axi_burst_arbiter
    import axi_node_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LOG_N_IN   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_IN*DATA_WIDTH-1:0]   data_i,
    input  logic [N_IN-1:0]              valid_i,
    input  logic [N_IN-1:0]              last_i,
    output logic [N_IN-1:0]              ready_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         last_o,
    output logic [LOG_N_IN-1:0]          id_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    lock_state_t           lock_q, lock_d;
    logic [LOG_N_IN-1:0]   grant_q, grant_d;
    logic [LOG_N_IN-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOG_N_IN-1:0]   sel_grant_s;
    logic                  sel_any_s;
    logic [LOG_N_IN-1:0]   grant_s;
    logic [LOG_N_IN-1:0]   rr_next_s;
    logic                  arb_valid_s;
    logic                  arb_last_s;
    logic [DATA_WIDTH-1:0] arb_data_s;
    logic                  arb_ready_s;
    logic                  xfer_s;
    logic [N_IN-1:0]       ready_s;
    logic                  hit_s;

    axi_rr_priority_sel #(
        .N_IN     (N_IN),
        .LOG_N_IN (LOG_N_IN)
    ) u_sel (
        .req_i       (valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (sel_grant_s),
        .any_valid_o (sel_any_s)
    );

    // Grant selection and AND-OR mux of the granted input onto the arbiter side.
    always_comb begin
        if (lock_q == LOCKED) begin
            grant_s = grant_q;
        end else begin
            grant_s = sel_grant_s;
        end
        arb_valid_s = 1'b0;
        arb_last_s  = 1'b0;
        arb_data_s  = '0;
        ready_s     = '0;
        hit_s       = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            hit_s       = (grant_s == LOG_N_IN'(k));
            arb_valid_s = arb_valid_s | (valid_i[k] & hit_s);
            arb_last_s  = arb_last_s  | (last_i[k]  & hit_s);
            arb_data_s  = arb_data_s  | (data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit_s}});
            // Reset forces all readies low so no beat is consumed while in reset.
            ready_s[k]  = hit_s & arb_ready_s & ~rst_i;
        end
        // Unlocked, the selector only lands on a requester when one exists.
        if (lock_q == LOCKED) begin
            arb_valid_s = arb_valid_s;
        end else begin
            arb_valid_s = sel_any_s;
        end
        xfer_s = arb_valid_s & arb_ready_s;
    end

    // Round-robin pointer successor with wrap from N_IN-1 to 0.
    always_comb begin
        if (grant_s == LOG_N_IN'(N_IN - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_s + LOG_N_IN'(1);
        end
    end

    // Lock / pointer next-state: release on last transfer, lock on any other offer.
    always_comb begin
        lock_d   = lock_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer_s && arb_last_s) begin
            lock_d   = UNLOCKED;
            rr_ptr_d = rr_next_s;
        end else if (arb_valid_s) begin
            lock_d  = LOCKED;
            grant_d = grant_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q   <= UNLOCKED;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign ready_o = ready_s;

`ifdef AXI_BURST_ARBITER_OUT_REG_EN
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LOG_N_IN-1:0]   id_q, id_d;

    // The slice can accept whenever it is empty or draining this cycle.
    assign arb_ready_s = ~valid_q | ready_i;

    // Output slice next-state: load on arbiter-side transfer, empty on drain.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
        if (xfer_s) begin
            valid_d = 1'b1;
            last_d  = arb_last_s;
            data_d  = arb_data_s;
            id_d    = grant_s;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output slice registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
    assign id_o    = id_q;
`else
    assign arb_ready_s = ready_i;
    // Combinational path; reset masks the offer so nothing appears valid in reset.
    assign valid_o = arb_valid_s & ~rst_i;
    assign last_o  = arb_last_s;
    assign data_o  = arb_data_s;
    assign id_o    = rst_i ? '0 : grant_s;
`endif

endmodule
